// File: rtl/iq_packer_pkg.sv
// Shared constants and helpers for the I/Q quantize-and-pack datapath.
package iq_packer_pkg;

  // Legal quantizer widths: sign only, sign+magnitude flag, coarse 4-bit
  localparam int Q_SIGN    = 1;
  localparam int Q_SIGNMAG = 2;
  localparam int Q_COARSE  = 4;

  // Number of set bits in a channel mask (masks up to 32 channels)
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/iq_lane_quant.sv
// One I or Q lane: DC correction with saturation (stage 1), then
// quantization to QBITS bits (stage 2). Registers only load on their strobe.
module iq_lane_quant
  import iq_packer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int QBITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load1,
  input  logic              load2,
  input  logic [IN_W-1:0]   sample,
  input  logic [IN_W-1:0]   dc,
  input  logic [IN_W-2:0]   thresh,
  output logic [QBITS-1:0]  code,
  output logic              sat
);

  localparam logic [IN_W-1:0] MAX_V = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MIN_V = {1'b1, {(IN_W-1){1'b0}}};

  logic [IN_W:0]      sum;
  logic [IN_W-1:0]    s_next;
  logic               sat_next;
  logic [IN_W-1:0]    s_reg;
  logic [QBITS-1:0]   code_next;

  // Widened add; the top two bits disagree exactly when the result overflows
  always_comb begin
    sum      = {sample[IN_W-1], sample} + {dc[IN_W-1], dc};
    sat_next = sum[IN_W] ^ sum[IN_W-1];
    s_next   = sum[IN_W-1:0];
    if (sat_next) begin
      s_next = sum[IN_W] ? MIN_V : MAX_V;
    end
  end

  // Stage 1: corrected, saturated sample plus its saturation flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_reg <= '0;
      sat   <= 1'b0;
    end else if (load1) begin
      s_reg <= s_next;
      sat   <= sat_next;
    end
  end

  generate
    if (QBITS == Q_SIGN) begin : g_sign
      assign code_next = s_reg[IN_W-1];
    end else if (QBITS == Q_SIGNMAG) begin : g_signmag
      // Magnitude kept unsigned at IN_W bits so the most negative value maps to 2^(IN_W-1)
      logic [IN_W-1:0] mag;
      assign mag       = s_reg[IN_W-1] ? (~s_reg + IN_W'(1)) : s_reg;
      assign code_next = {s_reg[IN_W-1], (mag >= {1'b0, thresh})};
    end else begin : g_coarse
      assign code_next = s_reg[IN_W-1 -: QBITS];
    end
  endgenerate

  // Stage 2: quantized code for this lane
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code <= '0;
    end else if (load2) begin
      code <= code_next;
    end
  end

endmodule

// File: rtl/iq_packer.sv
// Multi-channel I/Q quantizer and bit packer: corrects and quantizes every
// lane, concatenates the enabled channels and emits OUT_W-bit words.
module iq_packer
  import iq_packer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int IN_W  = 8,
  parameter int QBITS = 2,
  parameter int OUT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [NCH*IN_W-1:0] in_i,
  input  logic [NCH*IN_W-1:0] in_q,
  input  logic [NCH*IN_W-1:0] dc_i,
  input  logic [NCH*IN_W-1:0] dc_q,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [IN_W-2:0]     thresh,
  input  logic                sat_clear,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  output logic                sat_flag,
  output logic [15:0]         word_count
);

  localparam int LANES = 2 * NCH;
  localparam int SW    = LANES * QBITS;
  localparam int CW    = 2 * OUT_W;
  localparam int FW    = $clog2(CW + 1);

  generate
    if (SW > OUT_W) begin : g_bad_width
      $error("iq_packer: NCH*2*QBITS must not exceed OUT_W");
    end
    if (QBITS != Q_SIGN && QBITS != Q_SIGNMAG && QBITS != Q_COARSE) begin : g_bad_qbits
      $error("iq_packer: QBITS must be 1, 2 or 4");
    end
    if (NCH > 32) begin : g_bad_nch
      $error("iq_packer: NCH must not exceed 32");
    end
  endgenerate

  logic                enable_prev_reg;
  logic [NCH-1:0]      mask_l_reg;
  logic                s1_valid_reg;
  logic                s2_valid_reg;
  logic                load1;
  logic                load2;
  logic [QBITS-1:0]    code_lane [LANES];
  logic [LANES-1:0]    sat_lane;
  logic [LANES-1:0]    lane_mask;
  logic                new_sat;
  logic [SW-1:0]       sample_vec;
  logic [FW-1:0]       sample_bits;
  logic [OUT_W-1:0]    acc_reg;
  logic [FW-1:0]       fill_reg;
  logic [FW-1:0]       total;
  logic [CW-1:0]       merged;
  logic                word_done;

  assign load1 = enable & in_valid;
  assign load2 = enable & s1_valid_reg;

  // Pipeline valids and the channel mask captured on the enable rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_prev_reg <= 1'b0;
      mask_l_reg      <= '0;
      s1_valid_reg    <= 1'b0;
      s2_valid_reg    <= 1'b0;
    end else begin
      enable_prev_reg <= enable;
      if (enable && !enable_prev_reg) begin
        mask_l_reg <= ch_mask;
      end
      s1_valid_reg <= load1;
      s2_valid_reg <= load2;
    end
  end

  // Lane 2k is channel k's I, lane 2k+1 its Q
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign lane_mask[2*gi]   = mask_l_reg[gi];
      assign lane_mask[2*gi+1] = mask_l_reg[gi];

      iq_lane_quant #(.IN_W(IN_W), .QBITS(QBITS)) u_lane_i (
        .clk    (clk),
        .reset  (reset),
        .load1  (load1),
        .load2  (load2),
        .sample (in_i[gi*IN_W +: IN_W]),
        .dc     (dc_i[gi*IN_W +: IN_W]),
        .thresh (thresh),
        .code   (code_lane[2*gi]),
        .sat    (sat_lane[2*gi])
      );

      iq_lane_quant #(.IN_W(IN_W), .QBITS(QBITS)) u_lane_q (
        .clk    (clk),
        .reset  (reset),
        .load1  (load1),
        .load2  (load2),
        .sample (in_q[gi*IN_W +: IN_W]),
        .dc     (dc_q[gi*IN_W +: IN_W]),
        .thresh (thresh),
        .code   (code_lane[2*gi+1]),
        .sat    (sat_lane[2*gi+1])
      );
    end
  endgenerate

  assign new_sat = enable & s1_valid_reg & (|(sat_lane & lane_mask));

  // Sticky saturation flag; a fresh saturation beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= (sat_flag & ~sat_clear) | new_sat;
    end
  end

  // Compact enabled channels into a right-aligned vector, channel 0 most significant
  always_comb begin
    sample_vec = '0;
    for (int k = 0; k < NCH; k++) begin
      if (mask_l_reg[k]) begin
        sample_vec = (sample_vec << (2 * QBITS)) | SW'({code_lane[2*k], code_lane[2*k+1]});
      end
    end
    sample_bits = FW'(popcount(32'(mask_l_reg)) * 2 * QBITS);
  end

  // Place the new sample directly below the fill bits already held in the accumulator
  always_comb begin
    total     = fill_reg + sample_bits;
    merged    = {acc_reg, {OUT_W{1'b0}}} | (CW'(sample_vec) << (FW'(CW) - total));
    word_done = (total >= FW'(OUT_W));
  end

  // Packer: accumulate, emit a word once OUT_W bits are available, keep the remainder
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      fill_reg   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      word_count <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!enable) begin
        acc_reg  <= '0;
        fill_reg <= '0;
      end else if (s2_valid_reg) begin
        if (word_done) begin
          out_data   <= merged[CW-1 -: OUT_W];
          out_valid  <= 1'b1;
          acc_reg    <= merged[OUT_W-1:0];
          fill_reg   <= total - FW'(OUT_W);
          word_count <= word_count + 16'd1;
        end else begin
          acc_reg  <= merged[CW-1 -: OUT_W];
          fill_reg <= total;
        end
      end
    end
  end

endmodule

// File: doc/iq_packer.md
Name: iq_packer

Overview:
- Parametrised successor to the fixed 2-bit quantize-and-shift path that feeds packet_streamer.
- Takes NCH channels of 8-bit two's-complement I/Q samples, each already gray-decoded to binary.
- Per lane: adds a per-lane DC correction with saturation, then quantizes to QBITS bits.
- Packs the enabled lanes into a continuous bitstream and emits OUT_W-bit words with a valid strobe, for source_data/source_en.

Parameters:
NCH, 4, number of complex channels
IN_W, 8, input sample width (two's complement)
QBITS, 2, bits per quantized lane; legal values 1, 2, 4
OUT_W, 16, output word width; elaboration error unless NCH*2*QBITS <= OUT_W

Ports:
clk  in  1  sample clock (source_clk domain)
reset  in  1  asynchronous, active-high reset
enable  in  1  streaming enable; 0 flushes packer state
in_valid  in  1  one-cycle strobe: in_i/in_q hold a new sample
in_i  in  NCH*IN_W  I samples, lane k at [k*IN_W +: IN_W]
in_q  in  NCH*IN_W  Q samples, same layout
dc_i  in  NCH*IN_W  signed DC correction per I lane
dc_q  in  NCH*IN_W  signed DC correction per Q lane
ch_mask  in  NCH  channel enable; bit k enables channel k
thresh  in  IN_W-1  unsigned magnitude threshold (QBITS=2)
sat_clear  in  1  clears sat_flag
out_data  out  OUT_W  packed word
out_valid  out  1  one-cycle strobe with out_data
sat_flag  out  1  sticky: some enabled lane saturated
word_count  out  16  words emitted, wraps

Behaviour:
- Reset (async, active-high): out_data=0, out_valid=0, sat_flag=0, word_count=0, fill=0, accumulator=0, pipeline valids=0.
- Stage 1 (registered):
  - s = in + dc, computed at IN_W+1 bits.
  - Saturate to [-2^(IN_W-1), 2^(IN_W-1)-1].
  - Any enabled lane saturating sets sat_flag on the next edge.
  - sat_clear and a new saturation in the same cycle: sat_flag = 1 (set wins).
- Stage 2 (registered quantize), per lane:
  - QBITS=1: code = sign bit (1 = negative).
  - QBITS=2: code = {sign, |s| >= thresh}. |s| is computed at IN_W bits so that -128 gives 128.
  - QBITS=4: code = s[IN_W-1:IN_W-4].
- Lane order in the sample vector, MSB first: ch0 I, ch0 Q, ch1 I, ch1 Q, ... Disabled channels are omitted entirely.
- S = popcount(mask_l)*2*QBITS bits per sample.
- Configuration latch: ch_mask is latched into mask_l on the enable 0->1 edge. Changes while enable=1 are ignored. thresh and dc are live.
- Stage 3 (packer): accumulator holds fill bits, left-aligned. On each valid sample:
  - fill+S < OUT_W: append, fill += S, no output.
  - fill+S >= OUT_W: out_data = first OUT_W bits of {acc, sample}; out_valid=1 for one cycle; leftover bits kept; fill = fill+S-OUT_W (0 on exact fit); word_count += 1 (wraps at 0xFFFF->0).
- At most one word per sample, guaranteed by the S <= OUT_W parameter check.
- Latency: 3 clk edges from the in_valid that completes a word to out_valid.
- enable=0:
  - Samples are dropped, the partial word is discarded, fill=0.
  - In-flight pipeline samples are discarded; no out_valid until re-enabled.
  - word_count and sat_flag are held.
- mask_l=0: S=0, no words are emitted.
- in_valid gaps: the pipeline holds state; only valid samples advance the packer.

Decomposition:
- Package iq_packer_pkg: QBITS encoding constants (Q_SIGN=1, Q_SIGNMAG=2, Q_COARSE=4) and a popcount function.
- Sub-module iq_lane_quant: one lane's add, saturate and quantize, stages 1-2, with a saturation output.
  - Instantiated 2*NCH times by generate.
  - The packer stays in iq_packer.

Test Plan:
- Reset and idle: reset=1 with enable=1 and in_valid=1 -> out_valid=0, word_count=0, sat_flag=0. After release with enable=0, still no out_valid.
- NCH=2, QBITS=2, mask=11, thresh=32, dc=0, ch0=(+50,-50), ch1=(+5,-5), in_valid every cycle -> sample 0x72; out_data=0x7272 on every 2nd sample; word_count increments by 1 per word.
- Same settings, mask=01 latched at enable rise -> S=4, code 0x7; out_data=0x7777 every 4th sample. Changing mask to 11 mid-stream -> output unchanged.
- NCH=3, QBITS=2, mask=111 (S=12), samples coded 0xABC, 0xDEF, 0x123, 0x456 -> words 0xABCD, 0xEF12, 0x3456, then fill=0.
- Saturation: in_i=+0x7F, dc_i=+0x7F -> lane value +127 and sat_flag=1 two edges later. sat_clear pulse with no further saturation -> sat_flag=0. in_i=-128, dc=0, QBITS=2, thresh=127 -> code 11.
- Reset mid-word: with fill=8, assert enable=0 for one cycle and then re-enable -> the next word contains only new samples. Async reset mid-stream -> all outputs zero immediately, without waiting for a clock edge.
